// File: rtl/pipe_multilane_scrambler.sv
// pipe_multilane_scrambler: multi-byte PIPE TX scrambler, Gen1/2 (8b/10b) and Gen3+ (128b/130b) with registered output
module pipe_multilane_scrambler #(
  parameter int          MAX_BYTES    = 4,
  parameter logic [15:0] GEN12_INIT   = 16'hFFFF,
  parameter logic [22:0] DEFAULT_SEED = 23'h1DBFBC
) (
  input  logic                   pclk,
  input  logic                   reset,
  input  logic                   gen3Mode,
  input  logic                   turnOff,
  input  logic [6:0]             PIPEWIDTH,
  input  logic [23:0]            seedValue,
  input  logic [8*MAX_BYTES-1:0] dataIn,
  input  logic [MAX_BYTES-1:0]   dataKIn,
  input  logic                   dataValidIn,
  input  logic                   blockStart,
  input  logic [1:0]             syncHeader,
  input  logic                   isEieos,
  input  logic                   isSkpOs,
  output logic [8*MAX_BYTES-1:0] dataOut,
  output logic [MAX_BYTES-1:0]   dataKOut,
  output logic                   dataValidOut
);
  logic [15:0] lfsr12, g12_start, s12;
  logic [22:0] lfsr3, g3_start, s3, seed;
  logic [23:0] r12;
  logic [30:0] r3;
  logic [7:0] byt;
  logic [3:0] nb_raw, nb;
  logic [8*MAX_BYTES-1:0] dout;
  logic mode_q, blk_os, blk_skp, eieos_pending;
  logic mode_chg, cur_os, cur_skp, reseed, com, skp;
  logic unused_seed_msb;

  function automatic logic [23:0] step12(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0] o;
    t = s;
    for (int b = 0; b < 8; b++) begin
      o[b] = t[15];
      t = {t[14:0], 1'b0} ^ (t[15] ? 16'h0039 : 16'h0000);
    end
    return {t, o};
  endfunction

  function automatic logic [30:0] step3(input logic [22:0] s);
    logic [22:0] t;
    logic [7:0] o;
    t = s;
    for (int b = 0; b < 8; b++) begin
      o[b] = t[22];
      t = {t[21:0], 1'b0} ^ (t[22] ? 23'h210125 : 23'h000000);
    end
    return {t, o};
  endfunction

  assign unused_seed_msb = seedValue[23];
  assign seed = seedValue[22:0] == '0 ? DEFAULT_SEED : seedValue[22:0];
  assign nb_raw = PIPEWIDTH == 7'd8 ? 4'd1 : PIPEWIDTH == 7'd16 ? 4'd2 :
                  PIPEWIDTH == 7'd32 ? 4'd4 : PIPEWIDTH == 7'd64 ? 4'd8 : 4'd0;
  assign nb = nb_raw > 4'(MAX_BYTES) ? 4'd0 : nb_raw;
  assign mode_chg = gen3Mode != mode_q;
  assign cur_os = blockStart ? syncHeader == 2'b01 : blk_os;
  assign cur_skp = blockStart ? isSkpOs : blk_skp;
  // a pending EIEOS reseeds ahead of byte 0 of the next block
  assign reseed = mode_chg || (gen3Mode && dataValidIn && blockStart && eieos_pending);
  assign g12_start = mode_chg ? GEN12_INIT : lfsr12;
  assign g3_start = reseed ? seed : lfsr3;

  always_comb begin
    s12 = g12_start;
    s3 = g3_start;
    dout = '0;
    r12 = '0;
    r3 = '0;
    byt = '0;
    com = 1'b0;
    skp = 1'b0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      byt = dataIn[8*i +: 8];
      r12 = step12(s12);
      r3 = step3(s3);
      com = dataKIn[i] && byt == 8'hBC;
      skp = dataKIn[i] && byt == 8'h1C;
      if (4'(i) < nb) begin
        if (!gen3Mode) begin
          dout[8*i +: 8] = (dataKIn[i] || turnOff) ? byt : byt ^ r12[7:0];
          s12 = com ? GEN12_INIT : (skp || turnOff) ? s12 : r12[23:8];
        end else begin
          dout[8*i +: 8] = (cur_os || turnOff) ? byt : byt ^ r3[7:0];
          s3 = ((cur_os && cur_skp) || turnOff) ? s3 : r3[30:8];
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      dataOut <= '0;
      dataKOut <= '0;
      dataValidOut <= 1'b0;
      lfsr12 <= GEN12_INIT;
      lfsr3 <= DEFAULT_SEED;
      mode_q <= 1'b0;
      blk_os <= 1'b0;
      blk_skp <= 1'b0;
      eieos_pending <= 1'b0;
    end else begin
      mode_q <= gen3Mode;
      lfsr12 <= dataValidIn ? s12 : g12_start;
      lfsr3 <= dataValidIn ? s3 : g3_start;
      dataValidOut <= dataValidIn;
      if (dataValidIn) begin
        dataOut <= dout;
        dataKOut <= dataKIn;
      end
      if (dataValidIn && gen3Mode && blockStart) begin
        blk_os <= syncHeader == 2'b01;
        blk_skp <= isSkpOs;
        eieos_pending <= syncHeader == 2'b01 && isEieos;
      end
    end
endmodule
